// File: rtl/hazard_pkg.sv
// Shared constants and types for the forwarding / long-latency hazard unit.
// Forward-select encoding: 0 = register file, 1..NUM_FWD = pipeline stage, NUM_FWD+1 = long-latency writeback.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int FSEL_NONE = 0;

  typedef enum logic [1:0] {
    LOAD_USE = 2'd0,
    RAW_LAT  = 2'd1,
    WAW_LAT  = 2'd2,
    STRUCT   = 2'd3
  } stall_cause_e;

  function automatic int fsel_lat(input int num_fwd);
    return num_fwd + 1;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority matcher for one decode source port: youngest writing stage wins, then same-cycle long-latency bypass.
// Purely combinational, no backpressure.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int FSEL_W  = 3
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic                      rs_use,
  input  logic [NUM_FWD*REG_AW-1:0] rd_fwd,
  input  logic [NUM_FWD-1:0]        reg_write_fwd,
  input  logic                      lat_done,
  input  logic [REG_AW-1:0]         lat_done_rd,
  output logic [FSEL_W-1:0]         fsel
);

  always_comb begin
    fsel = FSEL_W'(FSEL_NONE);
    if (rs_use && (rs != '0)) begin
      if (lat_done && (lat_done_rd == rs)) begin
        fsel = FSEL_W'(fsel_lat(NUM_FWD));
      end
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (reg_write_fwd[j] && (rd_fwd[j*REG_AW +: REG_AW] == rs)) begin
          fsel = FSEL_W'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand forwarding select, same-cycle stall generation and a scoreboard for long-latency M-extension ops.
// Stalls are combinational (zero latency); scoreboard and counters update on the rising clock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_RS  = 2,
  parameter int NUM_FWD = 3,
  parameter int MAX_OUT = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_RS*REG_AW-1:0]        rs_i,
  input  logic [NUM_RS-1:0]               rs_use_i,
  input  logic [REG_AW-1:0]               rd_d_i,
  input  logic                            reg_write_d_i,
  input  logic                            is_lat_d_i,
  input  logic [NUM_FWD*REG_AW-1:0]       rd_fwd_i,
  input  logic [NUM_FWD-1:0]              reg_write_fwd_i,
  input  logic                            mem_read_ex_i,
  input  logic                            lat_issue_i,
  input  logic [REG_AW-1:0]               lat_issue_rd_i,
  input  logic                            lat_done_i,
  input  logic [REG_AW-1:0]               lat_done_rd_i,
  output logic [NUM_RS*$clog2(NUM_FWD+2)-1:0] fsel_o,
  output logic                            stall_o,
  output logic                            bubble_o,
  output logic [NUM_REGS-1:0]             busy_o,
  output logic [2:0]                      outstanding_o,
  output logic [31:0]                     stall_cnt_o,
  output logic                            err_o
);

  localparam int FSEL_W = $clog2(NUM_FWD + 2);
  localparam logic [FSEL_W-1:0] FSEL_LAT  = FSEL_W'(fsel_lat(NUM_FWD));
  localparam logic [FSEL_W-1:0] FSEL_EX   = FSEL_W'(1);
  localparam logic [2:0]        OUT_LIMIT = 3'(MAX_OUT);

  logic [NUM_REGS-1:0] busy;
  logic [2:0]          outstanding;
  logic [31:0]         stall_cnt;
  logic                err;

  logic [3:0]          cause;
  logic                stall;
  logic                done_hit;
  logic                done_ok, done_err;
  logic                issue_ok, issue_err;
  logic                full;

  genvar k;
  generate
    for (k = 0; k < NUM_RS; k++) begin : g_port
      fwd_select #(
        .NUM_FWD (NUM_FWD),
        .FSEL_W  (FSEL_W)
      ) u_fwd_select (
        .rs            (rs_i[k*REG_AW +: REG_AW]),
        .rs_use        (rs_use_i[k]),
        .rd_fwd        (rd_fwd_i),
        .reg_write_fwd (reg_write_fwd_i),
        .lat_done      (lat_done_i),
        .lat_done_rd   (lat_done_rd_i),
        .fsel          (fsel_o[k*FSEL_W +: FSEL_W])
      );
    end
  endgenerate

  assign full     = (outstanding == OUT_LIMIT);
  assign done_hit = lat_done_i && (lat_done_rd_i == rd_d_i);

  always_comb begin
    cause = '0;
    for (int p = 0; p < NUM_RS; p++) begin
      if (rs_use_i[p]) begin
        if (mem_read_ex_i && (fsel_o[p*FSEL_W +: FSEL_W] == FSEL_EX)) begin
          cause[LOAD_USE] = 1'b1;
        end
        // A result landing this very cycle is bypassed, so it does not hold decode.
        if ((rs_i[p*REG_AW +: REG_AW] != '0) && busy[rs_i[p*REG_AW +: REG_AW]] &&
            (fsel_o[p*FSEL_W +: FSEL_W] != FSEL_LAT)) begin
          cause[RAW_LAT] = 1'b1;
        end
      end
    end
    cause[WAW_LAT] = reg_write_d_i && (rd_d_i != '0) && busy[rd_d_i] && !done_hit;
    cause[STRUCT]  = is_lat_d_i && full && !lat_done_i;
  end

  assign stall    = |cause;
  assign stall_o  = stall;
  assign bubble_o = stall;

  // Illegal writebacks and over-issues are dropped so the count never leaves 0..MAX_OUT.
  assign done_err  = lat_done_i && ((outstanding == '0) || !busy[lat_done_rd_i]);
  assign done_ok   = lat_done_i && !done_err;
  assign issue_err = lat_issue_i && full && !done_ok;
  assign issue_ok  = lat_issue_i && !issue_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_ok && (lat_issue_rd_i == REG_AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (done_ok && (lat_done_rd_i == REG_AW'(r))) begin
          busy[r] <= 1'b0;
        end
      end
      busy[0] <= 1'b0;

      if (issue_ok && !done_ok) begin
        outstanding <= outstanding + 3'd1;
      end else if (done_ok && !issue_ok) begin
        outstanding <= outstanding - 3'd1;
      end

      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      if (done_err || issue_err) begin
        err <= 1'b1;
      end
    end
  end

  assign busy_o        = busy;
  assign outstanding_o = outstanding;
  assign stall_cnt_o   = stall_cnt;
  assign err_o         = err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (NUM_RS=2, NUM_FWD=3, MAX_OUT=2).
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rs_i;
  logic [1:0]  rs_use_i;
  logic [4:0]  rd_d_i;
  logic        reg_write_d_i;
  logic        is_lat_d_i;
  logic [14:0] rd_fwd_i;
  logic [2:0]  reg_write_fwd_i;
  logic        mem_read_ex_i;
  logic        lat_issue_i;
  logic [4:0]  lat_issue_rd_i;
  logic        lat_done_i;
  logic [4:0]  lat_done_rd_i;
  logic [5:0]  fsel_o;
  logic        stall_o;
  logic        bubble_o;
  logic [31:0] busy_o;
  logic [2:0]  outstanding_o;
  logic [31:0] stall_cnt_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs_i            (rs_i),
    .rs_use_i        (rs_use_i),
    .rd_d_i          (rd_d_i),
    .reg_write_d_i   (reg_write_d_i),
    .is_lat_d_i      (is_lat_d_i),
    .rd_fwd_i        (rd_fwd_i),
    .reg_write_fwd_i (reg_write_fwd_i),
    .mem_read_ex_i   (mem_read_ex_i),
    .lat_issue_i     (lat_issue_i),
    .lat_issue_rd_i  (lat_issue_rd_i),
    .lat_done_i      (lat_done_i),
    .lat_done_rd_i   (lat_done_rd_i),
    .fsel_o          (fsel_o),
    .stall_o         (stall_o),
    .bubble_o        (bubble_o),
    .busy_o          (busy_o),
    .outstanding_o   (outstanding_o),
    .stall_cnt_o     (stall_cnt_o),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_i = '0; rs_use_i = '0; rd_d_i = '0; reg_write_d_i = 1'b0; is_lat_d_i = 1'b0;
    rd_fwd_i = '0; reg_write_fwd_i = '0; mem_read_ex_i = 1'b0;
    lat_issue_i = 1'b0; lat_issue_rd_i = '0; lat_done_i = 1'b0; lat_done_rd_i = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_busy", busy_o, 32'h0);
    check("reset_outstanding", 32'(outstanding_o), 32'd0);
    check("reset_stall_cnt", stall_cnt_o, 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Forwarding priority: stage0 and stage1 both write r5.
    rs_i = {5'd0, 5'd5}; rs_use_i = 2'b01;
    rd_fwd_i = {5'd0, 5'd5, 5'd5}; reg_write_fwd_i = 3'b011; #1;
    check("fsel_youngest", 32'(fsel_o[2:0]), 32'd1);
    check("fsel_port1_zero", 32'(fsel_o[5:3]), 32'd0);
    check("fwd_no_stall", 32'(stall_o), 32'd0);
    reg_write_fwd_i = 3'b010; #1;
    check("fsel_stage1", 32'(fsel_o[2:0]), 32'd2);
    rd_fwd_i = {5'd5, 5'd0, 5'd0}; reg_write_fwd_i = 3'b100; #1;
    check("fsel_stage2", 32'(fsel_o[2:0]), 32'd3);
    rs_i = {5'd0, 5'd0}; rd_fwd_i = {5'd0, 5'd0, 5'd0}; reg_write_fwd_i = 3'b111; #1;
    check("fsel_x0", 32'(fsel_o[2:0]), 32'd0);
    rs_i = {5'd0, 5'd5}; rs_use_i = 2'b00; rd_fwd_i = {5'd5, 5'd5, 5'd5}; #1;
    check("fsel_unused", 32'(fsel_o[2:0]), 32'd0);

    // Load-use on port 1.
    clear_inputs();
    mem_read_ex_i = 1'b1; rd_fwd_i = {5'd0, 5'd0, 5'd7}; reg_write_fwd_i = 3'b001;
    rs_i = {5'd7, 5'd0}; rs_use_i = 2'b10; #1;
    check("load_use_stall", 32'(stall_o), 32'd1);
    check("load_use_bubble", 32'(bubble_o), 32'd1);
    step();
    check("stall_cnt_1", stall_cnt_o, 32'd1);
    rs_use_i = 2'b00; #1;
    check("load_use_unused", 32'(stall_o), 32'd0);
    step();
    check("stall_cnt_hold", stall_cnt_o, 32'd1);

    // RAW against a pending long-latency result on r10.
    clear_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd10;
    step();
    check("issue10_busy", busy_o, 32'h0000_0400);
    check("issue10_outstanding", 32'(outstanding_o), 32'd1);
    clear_inputs();
    rs_i = {5'd0, 5'd10}; rs_use_i = 2'b01; #1;
    check("raw_stall", 32'(stall_o), 32'd1);
    step();
    check("raw_stall_still", 32'(stall_o), 32'd1);
    step();
    check("stall_cnt_3", stall_cnt_o, 32'd3);
    lat_done_i = 1'b1; lat_done_rd_i = 5'd10; #1;
    check("bypass_fsel", 32'(fsel_o[2:0]), 32'd4);
    check("bypass_no_stall", 32'(stall_o), 32'd0);
    step();
    check("done10_busy", busy_o, 32'h0);
    check("done10_outstanding", 32'(outstanding_o), 32'd0);
    check("stall_cnt_after_done", stall_cnt_o, 32'd3);

    // Structural: two outstanding, decode another long-latency op.
    clear_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd3;
    step();
    lat_issue_rd_i = 5'd4;
    step();
    clear_inputs();
    check("full_outstanding", 32'(outstanding_o), 32'd2);
    check("full_busy", busy_o, 32'h0000_0018);
    is_lat_d_i = 1'b1; #1;
    check("struct_stall", 32'(stall_o), 32'd1);
    lat_done_i = 1'b1; lat_done_rd_i = 5'd3;
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd11; #1;
    check("struct_released", 32'(stall_o), 32'd0);
    step();
    check("swap_outstanding", 32'(outstanding_o), 32'd2);
    check("swap_busy", busy_o, 32'h0000_0810);
    check("swap_err", 32'(err_o), 32'd0);
    clear_inputs();
    lat_done_i = 1'b1; lat_done_rd_i = 5'd4;
    step();
    lat_done_rd_i = 5'd11;
    step();
    clear_inputs();
    check("drain_outstanding", 32'(outstanding_o), 32'd0);

    // Issue to x0 never marks busy; its writeback finds a clear bit.
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd0;
    step();
    check("x0_busy", busy_o, 32'h0);
    check("x0_outstanding", 32'(outstanding_o), 32'd1);
    clear_inputs();
    lat_done_i = 1'b1; lat_done_rd_i = 5'd0;
    step();
    check("x0_done_err", 32'(err_o), 32'd1);
    check("x0_done_outstanding", 32'(outstanding_o), 32'd1);
    clear_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd9;
    step();
    clear_inputs();
    reg_write_d_i = 1'b1; rd_d_i = 5'd9; #1;
    check("waw_stall", 32'(stall_o), 32'd1);
    lat_done_i = 1'b1; lat_done_rd_i = 5'd9;
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd9; #1;
    check("waw_bypass", 32'(stall_o), 32'd0);
    step();
    check("set_wins_busy", busy_o, 32'h0000_0200);
    check("set_wins_outstanding", 32'(outstanding_o), 32'd2);

    // Reset in the middle of a RAW stall.
    clear_inputs();
    rs_i = {5'd0, 5'd9}; rs_use_i = 2'b01; #1;
    check("raw9_stall", 32'(stall_o), 32'd1);
    step();
    check("stall_cnt_4", stall_cnt_o, 32'd4);
    rst_n = 1'b0; #1;
    check("midrst_busy", busy_o, 32'h0);
    check("midrst_stall_cnt", stall_cnt_o, 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    clear_inputs();
    lat_done_i = 1'b1; lat_done_rd_i = 5'd5;
    step();
    check("late_done_err", 32'(err_o), 32'd1);
    check("late_done_outstanding", 32'(outstanding_o), 32'd0);
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
